// File: rtl/demux_1to5_dispatch_pkg.sv
// Shared constants and select decode for the 1:5 write-side dispatcher.
package demux_1to5_dispatch_pkg;

    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned SEL_W   = 3;
    localparam logic [SEL_W-1:0] MAX_SEL = 3'd4;
    localparam int unsigned STAT_W  = 16;

    // Illegal selects decode to all-zero so they can never raise a channel valid.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            oh[k] = (sel == SEL_W'(k));
        end
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to5_dispatch_if.sv
// Producer/consumer handshake bundle for the 1:5 dispatcher.
interface demux_1to5_dispatch_if
    import demux_1to5_dispatch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [WIDTH-1:0]  in_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              err_sel;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_sel
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, err_sel
    );
endinterface

// File: rtl/demux_1to5_dispatch_fifo.sv
// In-order storage for {sel, data} entries; DEPTH must be 2 or 4.
module demux_1to5_dispatch_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is only observed while count_q is non-zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/demux_1to5_dispatch.sv
// Buffered 1:5 word dispatcher with select check and error pulse.
// Define DEMUX_DISPATCH_STATS_EN to add per-channel delivery and illegal-select counters.
module demux_1to5_dispatch
    import demux_1to5_dispatch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic clock,
    input  logic reset_n,
    demux_1to5_dispatch_if.slave bus
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_CH*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]        stat_err
`endif
);
    localparam int unsigned EW = WIDTH + SEL_W;

    logic             accept, legal, push, pop;
    logic             full, empty;
    logic [EW-1:0]    head;
    logic [SEL_W-1:0] head_sel;
    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] last_q;
    logic             err_q;

    assign legal  = (bus.in_sel <= MAX_SEL);
    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;

    demux_1to5_dispatch_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push),
        .wdata  ({bus.in_sel, bus.in_data}),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    assign head_sel  = head[EW-1 -: SEL_W];
    assign head_data = head[WIDTH-1:0];

    assign bus.in_ready  = !full;
    assign bus.out_valid = empty ? '0 : sel_onehot(head_sel);
    // When drained, the bus keeps showing the last delivered word.
    assign bus.out_data  = empty ? last_q : head_data;
    assign bus.err_sel   = err_q;
    assign pop           = |(bus.out_valid & bus.out_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            if (pop) begin
                last_q <= head_data;
            end
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_CH];
    logic [STAT_W-1:0] err_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            err_cnt_q <= '0;
        end else if (stat_clr) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            err_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + STAT_W'(1);
                end
            end
            if (accept && !legal && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + STAT_W'(1);
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            stat_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
        end
    end

    assign stat_err = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to5_dispatch.sv
// Self-checking bench for demux_1to5_dispatch against a queue-based reference model.
module tb_demux_1to5_dispatch;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    demux_1to5_dispatch_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_DISPATCH_STATS_EN
    logic        stat_clr = 1'b0;
    logic [79:0] stat_cnt;
    logic [15:0] stat_err;
`endif

    demux_1to5_dispatch #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_cnt(stat_cnt),
        .stat_err(stat_err)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0]       sel;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t            mq[$];
    logic [WIDTH-1:0] m_last;
    logic             m_err;
    int               m_cnt[5];
    int               m_errs;

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_err  = 1'b0;
        for (int k = 0; k < 5; k++) m_cnt[k] = 0;
        m_errs = 0;
    endtask

    function automatic logic [4:0] exp_ov();
        logic [4:0] one;
        one = 5'b00001;
        if (mq.size() == 0) return 5'b0;
        return one << mq[0].sel;
    endfunction

    function automatic logic [WIDTH-1:0] exp_od();
        if (mq.size() == 0) return m_last;
        return mq[0].data;
    endfunction

    // Advance one clock; decisions are taken from the inputs as seen before the edge.
    task automatic tick();
        bit    acc, ill, pop, clr;
        word_t h, w;
        acc    = (bus.in_valid === 1'b1) && (mq.size() < DEPTH);
        ill    = acc && (bus.in_sel > 3'd4);
        w.sel  = bus.in_sel;
        w.data = bus.in_data;
        pop    = 1'b0;
        h      = '0;
        clr    = 1'b0;
        if (mq.size() > 0) begin
            h   = mq[0];
            pop = (bus.out_ready[h.sel] === 1'b1);
        end
`ifdef DEMUX_DISPATCH_STATS_EN
        clr = stat_clr;
`endif
        @(posedge clock);
        #1;
        m_err = ill;
        if (pop) begin
            m_last = h.data;
            void'(mq.pop_front());
        end
        if (acc && !ill) mq.push_back(w);
        if (clr) begin
            for (int k = 0; k < 5; k++) m_cnt[k] = 0;
            m_errs = 0;
        end else begin
            if (pop && m_cnt[h.sel] < 65535) m_cnt[h.sel]++;
            if (ill && m_errs < 65535) m_errs++;
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 5'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd1;
        bus.in_data   = 32'h1234_5678;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 5'b00010) begin
            fails++; $display("FAIL reset_pre_ov got %b want %b", bus.out_valid, 5'b00010);
        end
        #3 reset_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL reset_ov got %b want 00000", bus.out_valid);
        end
        tests++; if (bus.out_data !== 32'h0) begin
            fails++; $display("FAIL reset_od got %h want 00000000", bus.out_data);
        end
        tests++; if (bus.err_sel !== 1'b0) begin
            fails++; $display("FAIL reset_err got %b want 0", bus.err_sel);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        tests++; if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ir got %b want 1", bus.in_ready);
        end
        tests++; if (bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL reset_idle_ov got %b want 00000", bus.out_valid);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 5'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd2;
        bus.in_data   = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.out_valid !== 5'b00100 || bus.out_data !== 32'hDEAD_BEEF) begin
                fails++; $display("FAIL single_hold[%0d] got %b/%h want 00100/deadbeef",
                                  i, bus.out_valid, bus.out_data);
            end
            if (i < 3) tick();
        end
        bus.out_ready = 5'b00100;
        tick();
        bus.out_ready = 5'b0;
        tests++; if (bus.out_valid !== 5'b0 || bus.out_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL single_pop got %b/%h want 00000/deadbeef",
                              bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_full();
        bus.out_ready = 5'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd0;
        bus.in_data   = 32'hAAAA_0000;
        tick();
        bus.in_sel  = 3'd4;
        bus.in_data = 32'hBBBB_4444;
        tick();
        tests++; if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL full_ir got %b want 0", bus.in_ready);
        end
        bus.in_sel  = 3'd1;
        bus.in_data = 32'hCCCC_1111;
        tick();
        tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 5'b00001) begin
            fails++; $display("FAIL full_hold got ir=%b ov=%b want ir=0 ov=00001",
                              bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 5'b00001;
        tick();
        tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 5'b10000 ||
                     bus.out_data !== 32'hBBBB_4444) begin
            fails++; $display("FAIL full_pop got ir=%b ov=%b od=%h want 1/10000/bbbb4444",
                              bus.in_ready, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 5'b11111;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 5'b00010 || bus.out_data !== 32'hCCCC_1111) begin
            fails++; $display("FAIL full_third got %b/%h want 00010/cccc1111",
                              bus.out_valid, bus.out_data);
        end
        tick();
        bus.out_ready = 5'b0;
        tests++; if (bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL full_drain got %b want 00000", bus.out_valid);
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] data[20];
        logic [4:0]       one;
        one = 5'b00001;
        bus.out_ready = 5'b11111;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                data[i]      = $urandom;
                bus.in_valid = 1'b1;
                bus.in_sel   = 3'(i % 5);
                bus.in_data  = data[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i < 20) begin
                tests++; if (bus.out_valid !== (one << (i % 5)) || bus.out_data !== data[i] ||
                             bus.in_ready !== 1'b1) begin
                    fails++; $display("FAIL stream[%0d] got ov=%b od=%h ir=%b want %b/%h/1",
                                      i, bus.out_valid, bus.out_data, bus.in_ready,
                                      one << (i % 5), data[i]);
                end
            end else begin
                tests++; if (bus.out_valid !== 5'b0) begin
                    fails++; $display("FAIL stream_end got %b want 00000", bus.out_valid);
                end
            end
        end
        bus.out_ready = 5'b0;
    endtask

    task automatic test_illegal();
        bus.out_ready = 5'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd6;
        bus.in_data   = 32'h0BAD_0BAD;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.err_sel !== 1'b1 || bus.out_valid !== 5'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL illegal_pulse got err=%b ov=%b ir=%b want 1/00000/1",
                              bus.err_sel, bus.out_valid, bus.in_ready);
        end
`ifdef DEMUX_DISPATCH_STATS_EN
        tests++; if (stat_err !== 16'(m_errs)) begin
            fails++; $display("FAIL illegal_stat got %0d want %0d", stat_err, m_errs);
        end
`endif
        tick();
        tests++; if (bus.err_sel !== 1'b0 || bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL illegal_after got err=%b ov=%b want 0/00000",
                              bus.err_sel, bus.out_valid);
        end
    endtask

    task automatic test_wrong_ready();
        bus.out_ready = 5'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 3'd3;
        bus.in_data   = 32'h3333_3333;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 5'b10111;
        tick();
        tick();
        tests++; if (bus.out_valid !== 5'b01000) begin
            fails++; $display("FAIL wrong_ready got %b want 01000", bus.out_valid);
        end
        bus.out_ready = 5'b01000;
        tick();
        bus.out_ready = 5'b0;
        tests++; if (bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL right_ready got %b want 00000", bus.out_valid);
        end
`ifdef DEMUX_DISPATCH_STATS_EN
        tests++; if (stat_cnt[3*16 +: 16] !== 16'(m_cnt[3])) begin
            fails++; $display("FAIL stat_cnt3 got %0d want %0d", stat_cnt[3*16 +: 16], m_cnt[3]);
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 5'b01000;
        stat_clr      = 1'b1;
        tick();
        stat_clr      = 1'b0;
        bus.out_ready = 5'b0;
        tests++; if (stat_cnt[3*16 +: 16] !== 16'h0 || bus.out_valid !== 5'b0) begin
            fails++; $display("FAIL stat_clr got cnt=%0d ov=%b want 0/00000",
                              stat_cnt[3*16 +: 16], bus.out_valid);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            // Producer holds its word while it is being refused.
            if (!(bus.in_valid && mq.size() >= DEPTH)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                           : 3'($urandom_range(0, 4));
                bus.in_data  = $urandom;
            end
            bus.out_ready = 5'($urandom);
`ifdef DEMUX_DISPATCH_STATS_EN
            stat_clr = ($urandom_range(0, 49) == 0);
`endif
            tick();
            tests++; if (bus.out_valid !== exp_ov() || bus.out_data !== exp_od()) begin
                fails++; $display("FAIL rand_out[%0d] got %b/%h want %b/%h",
                                  i, bus.out_valid, bus.out_data, exp_ov(), exp_od());
            end
            tests++; if (bus.in_ready !== (mq.size() < DEPTH) || bus.err_sel !== m_err) begin
                fails++; $display("FAIL rand_ctl[%0d] got ir=%b err=%b want %b/%b",
                                  i, bus.in_ready, bus.err_sel, mq.size() < DEPTH, m_err);
            end
        end
        bus.in_valid = 1'b0;
`ifdef DEMUX_DISPATCH_STATS_EN
        stat_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++; if (stat_cnt[k*16 +: 16] !== 16'(m_cnt[k])) begin
                fails++; $display("FAIL rand_stat_cnt[%0d] got %0d want %0d",
                                  k, stat_cnt[k*16 +: 16], m_cnt[k]);
            end
        end
        tests++; if (stat_err !== 16'(m_errs)) begin
            fails++; $display("FAIL rand_stat_err got %0d want %0d", stat_err, m_errs);
        end
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_data   = '0;
        bus.out_ready = 5'b0;
        model_reset();
        #12;
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_single();
        test_full();
        test_stream();
        test_illegal();
        test_wrong_ready();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
